tree_coeff_memory: RTL
======================

# tree_coeff_memory

Multi-channel coefficient store for the decision-tree spike classifier: it holds one node word per address and serves several tree-evaluation channels through a round-robin arbitrated, registered read port. A separate write port loads or updates nodes without a bidirectional bus. Per-word valid tracking makes never-written nodes read as zero after reset. It sits between the host loader and the per-channel node evaluators.

## Interface
- `WORDS`, 8, number of node words; address width `AW = $clog2(WORDS)` (min 1)
- `FEATURES`, 3, features per node
- `COEFF_BIT_DEPTH`, 4, bits per non-unity coefficient
- `BIAS_BIT_DEPTH`, 10, bias bits
- `CHANNELS`, 4, number of read requesters (≥1)
- Derived `W = 2 + FEATURES + (FEATURES-1)*COEFF_BIT_DEPTH + BIAS_BIT_DEPTH` (23 at defaults): {child-present[2], one-hot unity position[FEATURES], coefficients, bias}, MSB first

- `clk` in 1 — single clock, all logic on rising edge
- `reset` in 1 — synchronous, active-low
- `wr_en` in 1 — write strobe, always accepted
- `wr_addr` in AW — write address
- `wr_data` in W — write word
- `load` in 1 — loader owns memory; suppresses all read grants
- `rd_req` in CHANNELS — per-channel read request, held until granted
- `rd_addr` in CHANNELS*AW — channel i address at [i*AW +: AW], stable while requesting
- `rd_gnt` out CHANNELS — one-hot combinational grant
- `rd_valid` out CHANNELS — one-hot, registered; data for that channel on `rd_data`
- `rd_data` out W — registered read word

## Operation
- Storage: WORDS×W array, contents not reset; `vbit[WORDS]` valid bitmap cleared by reset, set by a write to that address.
- Write: `wr_en`=1 with `wr_addr` < WORDS writes `wr_data` and sets `vbit`. `wr_addr` ≥ WORDS: ignored.
- Arbitration: round-robin pointer `rr` (0 after reset). Grant to the first requesting channel at or after `rr` (wrapping). After a grant to channel g, `rr` ← (g+1) mod CHANNELS; with no grant `rr` holds. At most one grant per cycle.
- `rd_gnt` = 0 while `load`=1 or `reset`=0; requests remain pending and are served once `load` drops.
- Read result: if address < WORDS and `vbit` set, return stored word; otherwise return all-zero W bits (still with `rd_valid`).
- Handshake: a channel observes `rd_gnt[i]`=1, may drop or change `rd_req[i]`/address next cycle; data arrives in `rd_valid[i]`.
- Simultaneous write and granted read, same address: see Configuration. Different addresses: independent.

## Timing
- Grant in cycle N (combinational from that cycle's `rd_req`, `rr`, `load`) → `rd_valid[g]`=1 and `rd_data` in cycle N+1, for one cycle; a back-to-back grant in N+1 gives data in N+2 (one read per cycle throughput).
- Cycles with no grant: `rd_valid`=0, `rd_data` holds last value.
- Write in cycle N visible to reads granted in N+1 onward.
- Reset values: `rd_gnt`=0, `rd_valid`=0, `rd_data`=0, `rr`=0, `vbit`=0.
- Reset asserted in cycle N+1 after grant in N: `rd_valid` stays 0 (reset wins); the channel must re-request.
- `load` rising in the same cycle as a request: no grant that cycle.

## Configuration
- `TREE_COEFF_MEM_FWD_EN` defined: a read granted in the same cycle as a write to the same valid address returns `wr_data` (write-first forwarding), including an address whose `vbit` was previously clear.
- Not defined: the same read returns the pre-write contents (read-first), or zero if `vbit` was clear; the write still commits.

## Test plan
- Reset, then read channel 0 addr 3 (never written) → `rd_valid`=4'b0001 one cycle later, `rd_data`=0.
- Write addr 5 = 23'h1A2B3C, next cycle channel 2 reads addr 5 → grant 4'b0100, then `rd_valid`=4'b0100, `rd_data`=23'h1A2B3C.
- All four channels request continuously from reset → grants 0,1,2,3,0 on consecutive cycles, each data returned one cycle after its grant.
- Addr 2 holds 23'h000111; same cycle write 23'h7FFFFF to addr 2 and grant read of addr 2 → `rd_data`=23'h7FFFFF with `TREE_COEFF_MEM_FWD_EN`, 23'h000111 without.
- `load`=1 for 5 cycles with channels 1 and 3 requesting → no grants, `rd_valid`=0; `load` drops → channel 1 granted first cycle, channel 3 next.
- Grant in cycle N, `reset`=0 in N+1 → `rd_valid`=0, `rd_data`=0; previously written words read as 0 afterwards.

Source files
------------

// File: rtl/tree_coeff_memory_if.sv
// ---------------------------------------------------------------------------
// tree_coeff_memory_if
//
// Bus bundle for the decision-tree coefficient store: a write port used by the
// host loader and a multi-channel arbitrated read port used by the per-channel
// node evaluators.
//
// Signals:
//   wr_en, wr_addr, wr_data  - write strobe / address / node word
//   load                     - loader owns the memory, no read grants
//   rd_req[CHANNELS]         - per-channel read request (held until granted)
//   rd_addr[CHANNELS*AW]     - channel i address at [i*AW +: AW]
//   rd_gnt[CHANNELS]         - one-hot combinational grant
//   rd_valid[CHANNELS]       - one-hot registered data-valid
//   rd_data[W]               - registered read word
//
// Modports: master = loader/evaluator side, slave = memory side.
// ---------------------------------------------------------------------------
interface tree_coeff_memory_if #(
    parameter int WORDS           = 8,
    parameter int FEATURES        = 3,
    parameter int COEFF_BIT_DEPTH = 4,
    parameter int BIAS_BIT_DEPTH  = 10,
    parameter int CHANNELS        = 4
);
    localparam int AW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int W  = 2 + FEATURES + (FEATURES - 1) * COEFF_BIT_DEPTH + BIAS_BIT_DEPTH;

    logic                   wr_en;
    logic [AW-1:0]          wr_addr;
    logic [W-1:0]           wr_data;
    logic                   load;
    logic [CHANNELS-1:0]    rd_req;
    logic [CHANNELS*AW-1:0] rd_addr;
    logic [CHANNELS-1:0]    rd_gnt;
    logic [CHANNELS-1:0]    rd_valid;
    logic [W-1:0]           rd_data;

    modport master (
        output wr_en, wr_addr, wr_data, load, rd_req, rd_addr,
        input  rd_gnt, rd_valid, rd_data
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, load, rd_req, rd_addr,
        output rd_gnt, rd_valid, rd_data
    );
endinterface

// File: rtl/tree_coeff_memory.sv
// ---------------------------------------------------------------------------
// tree_coeff_memory
//
// Coefficient store for the decision-tree spike classifier. Holds WORDS node
// words of W bits ({child-present[2], one-hot unity position[FEATURES],
// coefficients, bias}, MSB first) and serves CHANNELS evaluators through a
// round-robin arbitrated read port with one cycle of latency.
//
// Ports:
//   clk    - single clock, rising edge
//   reset  - synchronous, active-low
//   bus    - tree_coeff_memory_if.slave (write port, load, read port)
//
// Never-written words read as zero after reset (per-word valid bitmap);
// out-of-range addresses read as zero and are ignored on write.
//
// Build option:
//   TREE_COEFF_MEM_FWD_EN - when defined, a read granted in the same cycle as
//   a write to the same address returns the write data (write-first). When
//   undefined the read returns the pre-write contents (read-first).
// ---------------------------------------------------------------------------
module tree_coeff_memory #(
    parameter int WORDS           = 8,
    parameter int FEATURES        = 3,
    parameter int COEFF_BIT_DEPTH = 4,
    parameter int BIAS_BIT_DEPTH  = 10,
    parameter int CHANNELS        = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    tree_coeff_memory_if.slave    bus
);
    localparam int AW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int W  = 2 + FEATURES + (FEATURES - 1) * COEFF_BIT_DEPTH + BIAS_BIT_DEPTH;
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic [W-1:0]        mem [WORDS];
    logic [WORDS-1:0]    vbit_reg;
    logic [CW-1:0]       rr_reg;
    logic [CW-1:0]       rr_next;
    logic [CHANNELS-1:0] rd_valid_reg;
    logic [W-1:0]        rd_data_reg;

    logic [CHANNELS-1:0] gnt;
    logic                gnt_any;
    logic [CW-1:0]       gnt_idx;
    logic [AW-1:0]       chan_addr [CHANNELS];
    logic [AW-1:0]       sel_addr;
    logic [W-1:0]        read_word;

    function automatic logic in_range(input logic [AW-1:0] a);
        return 32'(a) < 32'(WORDS);
    endfunction

    // Unpack the flat per-channel address bus.
    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan_addr
            assign chan_addr[gi] = bus.rd_addr[gi*AW +: AW];
        end
    endgenerate

    // Round-robin arbiter: scan channels starting at rr, first requester wins.
    // Reset and load both hold off every grant; requests simply stay pending.
    always_comb begin
        int c;
        gnt     = '0;
        gnt_any = 1'b0;
        gnt_idx = '0;
        c       = 0;
        if (reset && !bus.load) begin
            for (int k = 0; k < CHANNELS; k++) begin
                c = int'(rr_reg) + k;
                if (c >= CHANNELS) begin
                    c = c - CHANNELS;
                end
                if (!gnt_any && bus.rd_req[CW'(c)]) begin
                    gnt_any = 1'b1;
                    gnt_idx = CW'(c);
                end
            end
        end
        if (gnt_any) begin
            gnt[gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        rr_next = rr_reg;
        if (gnt_any) begin
            rr_next = (gnt_idx == CW'(CHANNELS - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    assign sel_addr = chan_addr[gnt_idx];

    // Word returned for the granted channel. Unwritten or out-of-range words
    // read as zero; the optional bypass makes a same-cycle write visible.
    always_comb begin
        read_word = '0;
        if (in_range(sel_addr) && vbit_reg[sel_addr]) begin
            read_word = mem[sel_addr];
        end
`ifdef TREE_COEFF_MEM_FWD_EN
        if (bus.wr_en && (bus.wr_addr == sel_addr) && in_range(sel_addr)) begin
            read_word = bus.wr_data;
        end
`endif
    end

    // Storage array: contents are never reset, validity lives in vbit_reg.
    always_ff @(posedge clk) begin
        if (bus.wr_en && in_range(bus.wr_addr)) begin
            mem[bus.wr_addr] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            vbit_reg <= '0;
        end else if (bus.wr_en && in_range(bus.wr_addr)) begin
            vbit_reg[bus.wr_addr] <= 1'b1;
        end
    end

    // Read pipeline register and arbitration pointer. rd_data holds its last
    // value on idle cycles so an evaluator may sample it late.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rr_reg       <= '0;
            rd_valid_reg <= '0;
            rd_data_reg  <= '0;
        end else begin
            rr_reg       <= rr_next;
            rd_valid_reg <= gnt;
            if (gnt_any) begin
                rd_data_reg <= read_word;
            end
        end
    end

    assign bus.rd_gnt   = gnt;
    assign bus.rd_valid = rd_valid_reg;
    assign bus.rd_data  = rd_data_reg;
endmodule
